sysid_check_master: RTL and testbench

SYSID_CHECK_MASTER -- requirements
Module: sysid_check_master

---
 rtl/sysid_check_pkg.sv | 28 ++
 rtl/sysid_timeout_ctr.sv | 32 +++
 rtl/sysid_check_master.sv | 157 +++++++++++++++
 tb/tb_sysid_check_master.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_check_pkg.sv
// ============================================================================
// Module : sysid_check_pkg
// Brief  : Shared states, status bit positions and word addresses.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sysid_check_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ID_REQ  = 3'd1,
      ID_WAIT = 3'd2,
      TS_REQ  = 3'd3,
      TS_WAIT = 3'd4,
      FINISH  = 3'd5
   } state_e;

   localparam int STATUS_ID_MISMATCH = 0;
   localparam int STATUS_TS_MISMATCH = 1;
   localparam int STATUS_TIMEOUT     = 2;

   localparam logic ADDR_ID = 1'b0;
   localparam logic ADDR_TS = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sysid_timeout_ctr.sv
// ============================================================================
// Module : sysid_timeout_ctr
// Brief  : 16-bit per-read cycle counter flagging when the read budget is used.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sysid_timeout_ctr #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic clock,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   logic [15:0] count_q;

   always_ff @(posedge clock) begin
      if (reset || clear_i) begin
         count_q <= '0;
      end else if (enable_i) begin
         count_q <= count_q + 16'd1;
      end
   end

   assign expired_o = (count_q == 16'(TIMEOUT_CYCLES - 1));

endmodule

`default_nettype wire

// File: rtl/sysid_check_master.sv
// ============================================================================
// Module : sysid_check_master
// Brief  : Reads system ID and build timestamp over Avalon-MM and checks them.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sysid_check_master
   import sysid_check_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h50A8_4AD9,
   parameter int unsigned TIMEOUT_CYCLES     = 256
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        address,
   output logic        read,
   input  logic        waitrequest,
   input  logic        readdatavalid,
   input  logic [31:0] readdata,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [2:0]  status,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   state_e      state_q;
   logic        read_q;
   logic        address_q;
   logic        busy_q;
   logic        done_q;
   logic        pass_q;
   logic [2:0]  status_q;
   logic [31:0] id_q;
   logic [31:0] ts_q;

   logic w_in_req;
   logic w_in_wait;
   logic w_rd_done;
   logic w_ctr_clear;
   logic w_ctr_enable;
   logic w_ctr_expired;

   assign w_in_req  = (state_q == ID_REQ)  || (state_q == TS_REQ);
   assign w_in_wait = (state_q == ID_WAIT) || (state_q == TS_WAIT);
   // A zero-latency slave completes the read in the accepting cycle itself.
   assign w_rd_done = readdatavalid && ((w_in_req && !waitrequest) || w_in_wait);

   assign w_ctr_clear  = (state_q == IDLE) || (state_q == FINISH) ||
                         (w_rd_done && ((state_q == ID_REQ) || (state_q == ID_WAIT)));
   assign w_ctr_enable = w_in_req || w_in_wait;

   sysid_timeout_ctr #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout_ctr (
      .clock     (clock),
      .reset     (reset),
      .clear_i   (w_ctr_clear),
      .enable_i  (w_ctr_enable),
      .expired_o (w_ctr_expired)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         read_q    <= 1'b0;
         address_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         status_q  <= '0;
         id_q      <= '0;
         ts_q      <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q   <= ID_REQ;
                  read_q    <= 1'b1;
                  address_q <= ADDR_ID;
                  busy_q    <= 1'b1;
                  pass_q    <= 1'b0;
                  status_q  <= '0;
                  id_q      <= '0;
                  ts_q      <= '0;
               end
            end
            ID_REQ, ID_WAIT: begin
               if (w_rd_done) begin
                  id_q      <= readdata;
                  state_q   <= TS_REQ;
                  read_q    <= 1'b1;
                  address_q <= ADDR_TS;
               end else if (w_ctr_expired) begin
                  read_q                   <= 1'b0;
                  busy_q                   <= 1'b0;
                  done_q                   <= 1'b1;
                  status_q[STATUS_TIMEOUT] <= 1'b1;
                  pass_q                   <= 1'b0;
                  state_q                  <= FINISH;
               end else if ((state_q == ID_REQ) && !waitrequest) begin
                  read_q  <= 1'b0;
                  state_q <= ID_WAIT;
               end
            end
            // Result is registered on entry to FINISH so it is valid alongside done.
            TS_REQ, TS_WAIT: begin
               if (w_rd_done) begin
                  ts_q                         <= readdata;
                  read_q                       <= 1'b0;
                  busy_q                       <= 1'b0;
                  done_q                       <= 1'b1;
                  status_q[STATUS_ID_MISMATCH] <= (id_q != EXPECTED_ID);
                  status_q[STATUS_TS_MISMATCH] <= (readdata != EXPECTED_TIMESTAMP);
                  pass_q                       <= (id_q == EXPECTED_ID) &&
                                                  (readdata == EXPECTED_TIMESTAMP);
                  state_q                      <= FINISH;
               end else if (w_ctr_expired) begin
                  read_q                       <= 1'b0;
                  busy_q                       <= 1'b0;
                  done_q                       <= 1'b1;
                  status_q[STATUS_ID_MISMATCH] <= (id_q != EXPECTED_ID);
                  status_q[STATUS_TIMEOUT]     <= 1'b1;
                  pass_q                       <= 1'b0;
                  state_q                      <= FINISH;
               end else if ((state_q == TS_REQ) && !waitrequest) begin
                  read_q  <= 1'b0;
                  state_q <= TS_WAIT;
               end
            end
            FINISH: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign address  = address_q;
   assign read     = read_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign pass     = pass_q;
   assign status   = status_q;
   assign id_value = id_q;
   assign ts_value = ts_q;

endmodule

`default_nettype wire

// File: tb/tb_sysid_check_master.sv
// ============================================================================
// Module : tb_sysid_check_master
// Brief  : Behavioural Avalon slave plus timing/result model for the checker.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sysid_check_master;

   localparam int          T      = 16;
   localparam logic [31:0] EXP_ID = 32'h0000_0000;
   localparam logic [31:0] EXP_TS = 32'h50A8_4AD9;
   localparam int          NEVER  = -1;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        waitrequest;
   logic        readdatavalid;
   logic [31:0] readdata;
   logic        address;
   logic        read;
   logic        busy;
   logic        done;
   logic        pass;
   logic [2:0]  status;
   logic [31:0] id_value;
   logic [31:0] ts_value;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   sysid_check_master #(
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .start         (start),
      .address       (address),
      .read          (read),
      .waitrequest   (waitrequest),
      .readdatavalid (readdatavalid),
      .readdata      (readdata),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .status        (status),
      .id_value      (id_value),
      .ts_value      (ts_value)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_read"},   32'(read),    0);
      chk({tag, "_addr"},   32'(address), 0);
      chk({tag, "_busy"},   32'(busy),    0);
      chk({tag, "_done"},   32'(done),    0);
      chk({tag, "_pass"},   32'(pass),    0);
      chk({tag, "_status"}, 32'(status),  0);
      chk({tag, "_id"},     id_value,     0);
      chk({tag, "_ts"},     ts_value,     0);
   endtask

   // One check sequence. s*: cycles waitrequest is held high before acceptance;
   // l*: cycles from acceptance to readdatavalid (0 = same cycle, NEVER = none).
   // xs: cycle of an extra start pulse (0 none, -1 random while busy);
   // rc: cycle in which reset is pulsed (0 none).
   task automatic run_seq(input int s0, input int l0, input logic [31:0] d0,
                          input int s1, input int l1, input logic [31:0] d1,
                          input int xs_in, input int rc);
      int          s[2];
      int          l[2];
      logic [31:0] d[2];
      bit          ok0, ok1;
      int          cyc0, cyc1, done_at, last, xs;
      int          n_done, stall_cnt, pend, pend_word, which;
      logic [2:0]  st_e;
      logic [31:0] id_e, ts_e;
      logic        pr, pw, pa;

      s[0] = s0; s[1] = s1; l[0] = l0; l[1] = l1; d[0] = d0; d[1] = d1;

      ok0     = (l0 >= 0) && (s0 + l0 <= T - 1);
      cyc0    = ok0 ? s0 + 1 + l0 : T;
      ok1     = ok0 && (l1 >= 0) && (s1 + l1 <= T - 1);
      cyc1    = ok1 ? s1 + 1 + l1 : T;
      done_at = 1 + cyc0 + (ok0 ? cyc1 : 0);
      id_e    = ok0 ? d0 : 32'd0;
      ts_e    = ok1 ? d1 : 32'd0;
      st_e    = {!ok1, ok1 && (d1 != EXP_TS), ok0 && (d0 != EXP_ID)};
      xs      = (xs_in < 0) ? int'($urandom_range(1, done_at)) : xs_in;
      last    = (rc != 0) ? rc + 30 : done_at + 30;

      @(posedge clock); #1;
      start = 1'b1; waitrequest = 1'b0; readdatavalid = 1'b0;
      stall_cnt = 0; pend = 0; pend_word = 0; which = 0; n_done = 0;
      pr = 1'b0; pw = 1'b0; pa = 1'b0;

      for (int c = 1; c <= last; c++) begin
         @(posedge clock); #1;
         start = (c == xs);
         reset = (c == rc);
         if (done) n_done++;

         if (rc != 0) begin
            chk("rst_no_done", 32'(done), 0);
            if (c == rc + 1) chk_all_zero("rst_clear");
         end else begin
            if (c == done_at) begin
               chk("done_pulse", 32'(done),   1);
               chk("pass",       32'(pass),   32'(st_e == 3'b000));
               chk("status",     32'(status), 32'(st_e));
               chk("id_value",   id_value,    id_e);
               chk("ts_value",   ts_value,    ts_e);
               chk("read_fin",   32'(read),   0);
            end else begin
               chk("done_low", 32'(done), 0);
            end
            if (c < done_at) chk("busy_hi", 32'(busy), 1);
            if (c > done_at) begin
               chk("busy_lo",   32'(busy), 0);
               chk("read_idle", 32'(read), 0);
            end
            if (read) chk("addr_word", 32'(address), 32'(which));
            if (pr && pw && c < done_at) begin
               chk("read_held",   32'(read),    1);
               chk("addr_stable", 32'(address), 32'(pa));
            end
         end

         readdatavalid = 1'b0;
         waitrequest   = 1'b0;
         readdata      = $urandom;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               readdatavalid = 1'b1;
               readdata      = d[pend_word];
            end
         end
         if (read) begin
            if (stall_cnt < s[int'(address)]) begin
               waitrequest = 1'b1;
               stall_cnt++;
            end else begin
               stall_cnt = 0;
               which++;
               if (l[int'(address)] == 0) begin
                  readdatavalid = 1'b1;
                  readdata      = d[int'(address)];
               end else if (l[int'(address)] > 0) begin
                  pend      = l[int'(address)];
                  pend_word = int'(address);
               end
            end
         end
         pr = read; pw = waitrequest; pa = address;
      end

      readdatavalid = 1'b0;
      waitrequest   = 1'b0;
      if (rc != 0) begin
         chk("rst_done_count", 32'(n_done), 0);
      end else begin
         chk("done_count",  32'(n_done), 1);
         chk("hold_pass",   32'(pass),   32'(st_e == 3'b000));
         chk("hold_status", 32'(status), 32'(st_e));
         chk("hold_id",     id_value,    id_e);
         chk("hold_ts",     ts_value,    ts_e);
      end
   endtask

   initial begin
      int          rs0, rs1, rl0, rl1, rx;
      logic [31:0] rd0, rd1;

      reset = 1'b1; start = 1'b0; waitrequest = 1'b0;
      readdatavalid = 1'b0; readdata = '0;
      repeat (3) @(posedge clock);
      #1;
      chk_all_zero("reset_state");
      reset = 1'b0;

      run_seq(0, 1, EXP_ID, 0, 1, EXP_TS, 0, 0);           // nominal, done at 5
      run_seq(0, 1, 32'h1, 0, 1, EXP_TS, 0, 0);            // ID mismatch
      run_seq(10, 1, EXP_ID, 10, 1, EXP_TS, 0, 0);         // stalls, done at 25
      run_seq(0, 1, EXP_ID, 0, 20, EXP_TS, 0, 0);          // TS timeout, late data
      run_seq(0, 0, EXP_ID, 0, 0, 32'hDEAD_BEEF, 0, 0);    // zero latency, TS mismatch
      run_seq(20, 1, EXP_ID, 0, 1, EXP_TS, 0, 0);          // ID timeout while stalled
      run_seq(0, 1, EXP_ID, 0, 2, EXP_TS, 0, 4);           // reset in TS_WAIT
      run_seq(0, 1, EXP_ID, 0, 1, EXP_TS, 0, 0);           // recovery after reset
      run_seq(3, 2, EXP_ID, 1, 1, EXP_TS, 2, 0);           // start while busy
      run_seq(0, 1, EXP_ID, T - 2, 1, EXP_TS, 0, 0);       // completes on last budget cycle
      run_seq(0, 1, EXP_ID, T - 1, 1, EXP_TS, 0, 0);       // one cycle over budget

      for (int i = 0; i < 24; i++) begin
         rs0 = int'($urandom_range(0, 5));
         rs1 = int'($urandom_range(0, 5));
         rl0 = int'($urandom_range(0, 9));
         rl1 = int'($urandom_range(0, 9));
         if (rl0 > 3) rl0 = (rl0 == 9) ? NEVER : (rl0 == 8 ? 20 : 1);
         if (rl1 > 3) rl1 = (rl1 == 9) ? NEVER : (rl1 == 8 ? 20 : 1);
         rd0 = $urandom_range(0, 1) ? EXP_ID : $urandom;
         rd1 = $urandom_range(0, 1) ? EXP_TS : $urandom;
         rx  = $urandom_range(0, 1) ? -1 : 0;
         run_seq(rs0, rl0, rd0, rs1, rl1, rd1, rx, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
